pe_array_ctrl: RTL and testbench

//  Job sequencer for the 8-lane pe_array. Accepts one conv/maxpool command at a time and reads

---
 rtl/pe_array_ctrl.sv | 159 +++++++++++++++
 tb/tb_pe_array_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: job sequencer for the 8-lane pe_array; define PE_CTRL_RELU_EN to clamp conv result lanes at zero
module pe_array_ctrl #(
    parameter int ADDR_W       = 10,
    parameter int LEN_W        = 8,
    parameter int DRAIN_CYCLES = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int WORD_WIDTH   = 8 * DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_mode_i,
    input  logic [LEN_W-1:0]      cmd_len_i,
    input  logic [ADDR_W-1:0]     cmd_fbase_i,
    input  logic [ADDR_W-1:0]     cmd_wbase_i,
    input  logic                  abort_i,
    output logic                  fa_re_o,
    output logic [ADDR_W-1:0]     fa_addr_o,
    input  logic [WORD_WIDTH-1:0] fa_word_i,
    output logic                  wt_re_o,
    output logic [ADDR_W-1:0]     wt_addr_o,
    input  logic [DATA_WIDTH-1:0] wt_data_i,
    output logic                  pe_clr_o,
    output logic                  pe_we_o,
    output logic [1:0]            pe_mode_o,
    output logic [WORD_WIDTH-1:0] pe_srca_o,
    output logic [DATA_WIDTH-1:0] pe_srcb_o,
    input  logic [WORD_WIDTH-1:0] pe_wordp_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [WORD_WIDTH-1:0] res_word_o,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam int DC_W  = $clog2(DRAIN_CYCLES + 2);
    localparam int LANES = WORD_WIDTH / DATA_WIDTH;

    logic [2:0]            state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      idx_q, idx_d;
    logic [ADDR_W-1:0]     fbase_q, fbase_d;
    logic [ADDR_W-1:0]     wbase_q, wbase_d;
    logic [DC_W-1:0]       dcnt_q, dcnt_d;
    logic                  rd_q, rd_d;
    logic                  err_q, err_d;
    logic [WORD_WIDTH-1:0] res_q, res_d;
    logic [WORD_WIDTH-1:0] cap_word;
    logic                  run, conv, dv;

    assign conv = (mode_q == 2'b00);
    assign run  = (state_q == S_RUN) && !abort_i;
    // dv marks the cycle whose buffer data belongs to the current job
    assign dv   = rd_q && !abort_i;

`ifdef PE_CTRL_RELU_EN
    for (genvar l = 0; l < LANES; l++) begin : g_relu
        assign cap_word[l*DATA_WIDTH +: DATA_WIDTH] =
            (conv && pe_wordp_i[l*DATA_WIDTH + DATA_WIDTH - 1]) ? '0 : pe_wordp_i[l*DATA_WIDTH +: DATA_WIDTH];
    end
`else
    assign cap_word = pe_wordp_i;
`endif

    // next-state logic: command latch, read sequencing, drain count and result capture
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        idx_d   = idx_q;
        fbase_d = fbase_q;
        wbase_d = wbase_q;
        dcnt_d  = dcnt_q;
        res_d   = res_q;
        err_d   = 1'b0;
        if (state_q != S_IDLE && abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (cmd_valid_i) begin
                    mode_d  = cmd_mode_i;
                    len_d   = cmd_len_i;
                    fbase_d = cmd_fbase_i;
                    wbase_d = cmd_wbase_i;
                    err_d   = cmd_mode_i[1];
                    state_d = cmd_mode_i[1] ? S_IDLE : S_CLEAR;
                end
                S_CLEAR: begin
                    idx_d   = '0;
                    dcnt_d  = '0;
                    state_d = (len_q == '0) ? S_DRAIN : S_RUN;
                end
                S_RUN: begin
                    idx_d   = idx_q + LEN_W'(1);
                    state_d = (idx_q == len_q - LEN_W'(1)) ? S_DRAIN : S_RUN;
                end
                S_DRAIN: begin
                    dcnt_d = dcnt_q + DC_W'(1);
                    if (dcnt_q == DC_W'(DRAIN_CYCLES)) begin
                        res_d   = cap_word;
                        state_d = S_DONE;
                    end
                end
                S_DONE: state_d = res_ready_i ? S_IDLE : S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign rd_d = fa_re_o;

    // state registers, cleared asynchronously so a reset mid-job drops everything at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            fbase_q <= '0;
            wbase_q <= '0;
            dcnt_q  <= '0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            fbase_q <= fbase_d;
            wbase_q <= wbase_d;
            dcnt_q  <= dcnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            res_q   <= res_d;
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign err_o       = err_q;
    assign fa_re_o     = run;
    assign fa_addr_o   = run ? fbase_q + ADDR_W'(idx_q) : '0;
    assign wt_re_o     = run && conv;
    assign wt_addr_o   = (run && conv) ? wbase_q + ADDR_W'(idx_q) : '0;
    assign pe_clr_o    = (state_q == S_CLEAR);
    assign pe_we_o     = dv || ((state_q == S_CLEAR) && !abort_i);
    assign pe_mode_o   = busy_o ? mode_q : 2'b00;
    assign pe_srca_o   = dv ? fa_word_i : '0;
    assign pe_srcb_o   = (dv && conv) ? wt_data_i : '0;
    assign res_valid_o = (state_q == S_DONE) && !abort_i;
    assign res_word_o  = res_q;
endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl: directed bench with buffer and pe_array models around pe_array_ctrl
module tb_pe_array_ctrl;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid, cmd_ready, abort, fa_re, wt_re, pe_clr, pe_we;
    logic [1:0]   cmd_mode, pe_mode;
    logic [7:0]   cmd_len;
    logic [9:0]   cmd_fbase, cmd_wbase, fa_addr, wt_addr;
    logic [127:0] fa_word, pe_srca, pe_wordp, res_word;
    logic [15:0]  wt_data, pe_srcb;
    logic         res_valid, res_ready, busy, err;
    logic [127:0] fmem [1024];
    logic [15:0]  wmem [1024];
    logic [127:0] acc, p0, p1, p2;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pe_array_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_mode_i(cmd_mode),
        .cmd_len_i(cmd_len), .cmd_fbase_i(cmd_fbase), .cmd_wbase_i(cmd_wbase),
        .abort_i(abort),
        .fa_re_o(fa_re), .fa_addr_o(fa_addr), .fa_word_i(fa_word),
        .wt_re_o(wt_re), .wt_addr_o(wt_addr), .wt_data_i(wt_data),
        .pe_clr_o(pe_clr), .pe_we_o(pe_we), .pe_mode_o(pe_mode),
        .pe_srca_o(pe_srca), .pe_srcb_o(pe_srcb), .pe_wordp_i(pe_wordp),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_word_o(res_word),
        .busy_o(busy), .err_o(err)
    );

    function automatic logic [127:0] pack(input int v [8]);
        logic [127:0] w;
        for (int k = 0; k < 8; k++) w[16*k +: 16] = 16'(v[k] * 256);
        return w;
    endfunction

    function automatic logic [127:0] pe_next(input logic [127:0] a, input logic [127:0] s,
                                             input logic [15:0] b, input logic [1:0] m);
        logic [127:0] r;
        logic signed [15:0] x, y;
        logic signed [31:0] p;
        for (int k = 0; k < 8; k++) begin
            x = a[16*k +: 16];
            y = s[16*k +: 16];
            p = y * $signed(b);
            r[16*k +: 16] = (m == 2'b01) ? ((y > x) ? y : x) : x + p[23:8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (fa_re) fa_word <= fmem[fa_addr];
        if (wt_re) wt_data <= wmem[wt_addr];
    end

    always @(posedge clk) begin
        if (pe_we) acc <= pe_clr ? ((pe_mode == 2'b01) ? {8{16'h8000}} : '0) : pe_next(acc, pe_srca, pe_srcb, pe_mode);
        p0 <= acc;
        p1 <= p0;
        p2 <= p1;
    end
    assign pe_wordp = p2;

    task automatic run_job(input logic [1:0] m, input int n, input int fb, input int wb,
                           output int lat, output logic [127:0] word, output bit wt_seen);
        @(negedge clk);
        cmd_mode = m; cmd_len = 8'(n); cmd_fbase = 10'(fb); cmd_wbase = 10'(wb); cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        wt_seen = 0;
        do begin
            @(negedge clk);
            lat++;
            if (wt_re) wt_seen = 1;
        end while (!res_valid && lat < 100);
        word = res_word;
    endtask

    task automatic finish_job(input string name);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_after: cmd_ready=%b res_valid=%b expected 1/0", name, cmd_ready, res_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 0; cmd_mode = 0; cmd_len = 0; cmd_fbase = 0; cmd_wbase = 0;
        abort = 0; res_ready = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++;
        if ({busy, res_valid, err} !== 3'b000) begin errors++; $display("FAIL reset_status: busy/valid/err=%b expected 000", {busy, res_valid, err}); end
        checks++;
        if ({fa_re, wt_re, pe_we, pe_clr} !== 4'b0000) begin errors++; $display("FAIL reset_enables: got %b expected 0000", {fa_re, wt_re, pe_we, pe_clr}); end
        checks++;
        if (res_word !== '0) begin errors++; $display("FAIL reset_res_word: got %h expected 0", res_word); end
        checks++;
        if ({pe_mode, fa_addr, wt_addr} !== 22'd0) begin errors++; $display("FAIL reset_mode_addr: got %h expected 0", {pe_mode, fa_addr, wt_addr}); end
        rst_n = 1'b1;
    endtask

    task automatic test_conv();
        int r[8];
        int lat;
        bit ws;
        logic [127:0] w, exp;
        r = '{1, 2, 3, 4, 5, 6, 7, 8};
        fmem[1022] = pack(r); fmem[1023] = pack(r); fmem[0] = pack(r); fmem[1] = pack(r);
        wmem[1021] = 16'h0100; wmem[1022] = 16'h0200; wmem[1023] = 16'h0300; wmem[0] = 16'h0400;
        for (int k = 0; k < 8; k++) exp[16*k +: 16] = 16'(10 * (k + 1) * 256);
        run_job(2'b00, 4, 1022, 1021, lat, w, ws);
        checks++;
        if (lat != 11) begin errors++; $display("FAIL conv_latency: got %0d expected 11", lat); end
        checks++;
        if (w !== exp) begin errors++; $display("FAIL conv_result: got %h expected %h", w, exp); end
        checks++;
        if (ws !== 1'b1) begin errors++; $display("FAIL conv_wt_re: got %b expected 1", ws); end
        finish_job("conv");
    endtask

    task automatic test_maxpool();
        int r[8];
        int lat;
        bit ws;
        logic [127:0] w, exp;
        r = '{5, 3, 9, 2, 7, 1, 4, 8}; fmem[100] = pack(r);
        r = '{2, 8, 1, 6, 3, 9, 5, 4}; fmem[101] = pack(r);
        r = '{7, 4, 6, 9, 1, 5, 8, 2}; fmem[102] = pack(r);
        r = '{7, 8, 9, 9, 7, 9, 8, 8}; exp = pack(r);
        run_job(2'b01, 3, 100, 200, lat, w, ws);
        checks++;
        if (lat != 10) begin errors++; $display("FAIL maxpool_latency: got %0d expected 10", lat); end
        checks++;
        if (w !== exp) begin errors++; $display("FAIL maxpool_result: got %h expected %h", w, exp); end
        checks++;
        if (ws !== 1'b0) begin errors++; $display("FAIL maxpool_wt_re: got %b expected 0", ws); end
        checks++;
        if (pe_mode !== 2'b01) begin errors++; $display("FAIL maxpool_pe_mode: got %b expected 01", pe_mode); end
        finish_job("maxpool");
    endtask

    task automatic test_backpressure();
        int r[8];
        int lat;
        bit ws;
        logic [127:0] w, exp;
        r = '{1, 2, 3, 4, 5, 6, 7, 8};
        fmem[300] = pack(r); fmem[301] = pack(r);
        wmem[400] = 16'h0100; wmem[401] = 16'h0100;
        for (int k = 0; k < 8; k++) exp[16*k +: 16] = 16'(2 * (k + 1) * 256);
        run_job(2'b00, 2, 300, 400, lat, w, ws);
        checks++;
        if (w !== exp) begin errors++; $display("FAIL bp_result: got %h expected %h", w, exp); end
        cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_len = 8'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_word !== exp || cmd_ready !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%b word=%h ready=%b err=%b expected 1/%h/0/0", i, res_valid, res_word, cmd_ready, err, exp);
            end
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: ready=%b valid=%b err=%b expected 1/0/0", cmd_ready, res_valid, err);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_late_accept: err=%b busy=%b expected 1/0", err, busy); end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL bp_err_width: err=%b expected 0", err); end
    endtask

    task automatic test_illegal_and_empty();
        int pulses = 0;
        bit bz = 0;
        bit re = 0;
        int lat;
        bit ws;
        logic [127:0] w;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_len = 8'd3;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (err) pulses++;
            if (busy) bz = 1;
            if (fa_re || wt_re) re = 1;
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL illegal_err_pulses: got %0d expected 1", pulses); end
        checks++;
        if (bz !== 1'b0) begin errors++; $display("FAIL illegal_busy: got %b expected 0", bz); end
        checks++;
        if (re !== 1'b0) begin errors++; $display("FAIL illegal_reads: got %b expected 0", re); end
        run_job(2'b00, 0, 50, 60, lat, w, ws);
        checks++;
        if (lat != 7) begin errors++; $display("FAIL empty_latency: got %0d expected 7", lat); end
        checks++;
        if (w !== '0) begin errors++; $display("FAIL empty_result: got %h expected 0", w); end
        finish_job("empty");
    endtask

    task automatic test_abort();
        int r[8];
        int n = 0;
        int lat;
        bit ws;
        bit vs = 0;
        logic [127:0] w, exp;
        r = '{1, 2, 3, 4, 5, 6, 7, 8};
        for (int i = 0; i < 8; i++) begin fmem[500 + i] = pack(r); wmem[500 + i] = 16'h0100; end
        for (int i = 0; i < 4; i++) wmem[600 + i] = 16'((i + 1) * 256);
        for (int k = 0; k < 8; k++) exp[16*k +: 16] = 16'(10 * (k + 1) * 256);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_len = 8'd8; cmd_fbase = 10'd500; cmd_wbase = 10'd500;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        do begin @(negedge clk); n++; end while (!(fa_re && fa_addr == 10'd502) && n < 20);
        checks++;
        if (fa_re !== 1'b1 || fa_addr !== 10'd502) begin errors++; $display("FAIL abort_reach_i2: fa_re=%b addr=%0d expected 1/502", fa_re, fa_addr); end
        abort = 1'b1;
        #1;
        checks++;
        if (fa_re !== 1'b0 || wt_re !== 1'b0 || pe_we !== 1'b0) begin
            errors++;
            $display("FAIL abort_gate: fa_re=%b wt_re=%b pe_we=%b expected 000", fa_re, wt_re, pe_we);
        end
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: busy=%b ready=%b expected 0/1", busy, cmd_ready); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_valid) vs = 1;
        end
        checks++;
        if (vs !== 1'b0) begin errors++; $display("FAIL abort_no_result: res_valid seen=%b expected 0", vs); end
        run_job(2'b00, 4, 500, 600, lat, w, ws);
        checks++;
        if (w !== exp) begin errors++; $display("FAIL abort_followup: got %h expected %h", w, exp); end
        finish_job("abort");
    endtask

    task automatic test_relu();
        int lat;
        bit ws;
        logic [127:0] w, exp;
        fmem[700] = {8{16'h0300}};
        wmem[800] = 16'hFF00;
`ifdef PE_CTRL_RELU_EN
        exp = '0;
`else
        exp = {8{16'hFD00}};
`endif
        run_job(2'b00, 1, 700, 800, lat, w, ws);
        checks++;
        if (lat != 8) begin errors++; $display("FAIL relu_latency: got %0d expected 8", lat); end
        checks++;
        if (w !== exp) begin errors++; $display("FAIL relu_result: got %h expected %h", w, exp); end
        finish_job("relu");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_len = 8'd8; cmd_fbase = 10'd500; cmd_wbase = 10'd500;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL areset_started: busy=%b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || fa_re !== 1'b0 || res_word !== '0) begin
            errors++;
            $display("FAIL areset_immediate: busy=%b ready=%b fa_re=%b word=%h expected 0/1/0/0", busy, cmd_ready, fa_re, res_word);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_conv();
        test_maxpool();
        test_backpressure();
        test_illegal_and_empty();
        test_abort();
        test_relu();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
